// File: rtl/uart_pkg.sv
// Shared UART receive constants and helpers.
// Frame geometry and parity mode encodings.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    // Data bits plus the optional parity bit.
    function automatic int frame_bits(input int data_bits, input bit parity_en);
        return data_bits + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_rx_datapath_if.sv
// Received-frame valid/ready bundle.
// Master drives data, flags and valid; slave drives ready.
interface uart_rx_datapath_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_holding.sv
// Single-entry holding register for received frames.
// A commit into a full, unaccepted entry is dropped and flagged.
module uart_rx_holding #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_commit,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_parity_err,
    input  logic                 i_frame_err,
    uart_rx_datapath_if.master   rx_if
);

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 w_load;
    logic                 w_drop;

    assign w_drop = i_commit & r_valid & ~rx_if.rx_ready;
    assign w_load = i_commit & ~w_drop;

    // Entry update: load on accepted commit, empty on consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_drop;
            if (w_load) begin
                r_data  <= i_data;
                r_perr  <= i_parity_err;
                r_ferr  <= i_frame_err;
                r_valid <= 1'b1;
            end else if (r_valid & rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data     = r_data;
    assign rx_if.rx_valid    = r_valid;
    assign rx_if.parity_err  = r_perr;
    assign rx_if.frame_err   = r_ferr;
    assign rx_if.overrun_err = r_ovr;

endmodule

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: shift register, bit counter, parity.
// Frames are committed to the holding register on load_shift rise.
module uart_rx_datapath
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rxd_in,
    input  logic               rxd_shift,
    input  logic               rxd_count,
    input  logic               clear_bit,
    input  logic               load_shift,
    input  logic               parity_check,
    output logic               bit_done,
    uart_rx_datapath_if.master rx_if
);

    localparam int FB = frame_bits(DATA_BITS, PARITY_EN);
    localparam int CW = $clog2(FB + 1);
    localparam logic [CW-1:0] FB_C = CW'(FB);

    logic [FB-1:0] r_shift;
    logic [CW-1:0] r_count;
    logic          r_load_d;
    logic          w_commit;
    logic          w_perr;
    logic          w_ferr;

    // Shift LSB-first and count bits; clear wins over both.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (clear_bit) begin
            r_shift <= '0;
            r_count <= '0;
        end else begin
            if (rxd_shift) begin
                r_shift <= {rxd_in, r_shift[FB-1:1]};
            end
            if (rxd_count && (r_count != FB_C)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Remember load_shift so only its first cycle commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_d <= 1'b0;
        end else begin
            r_load_d <= load_shift;
        end
    end

    assign w_commit = load_shift & ~r_load_d;
    assign bit_done = (r_count == FB_C);
    assign w_ferr   = ~rxd_in;
    assign w_perr   = PARITY_EN & parity_check
                    & ((^r_shift) ^ PARITY_ODD);

    uart_rx_holding #(
        .DATA_BITS (DATA_BITS)
    ) u_holding (
        .clk          (clk),
        .reset        (reset),
        .i_commit     (w_commit),
        .i_data       (r_shift[DATA_BITS-1:0]),
        .i_parity_err (w_perr),
        .i_frame_err  (w_ferr),
        .rx_if        (rx_if)
    );

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Scoreboard bench for uart_rx_datapath.
// Random and directed frames against a frame-level model.
module tb_uart_rx_datapath;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd_in = 1'b1;
    logic rxd_shift = 1'b0;
    logic rxd_count = 1'b0;
    logic clear_bit = 1'b0;
    logic load_shift = 1'b0;
    logic parity_check = 1'b0;
    logic bit_done;

    logic np_rxd = 1'b1;
    logic np_shift = 1'b0;
    logic np_count = 1'b0;
    logic np_clear = 1'b0;
    logic np_load = 1'b0;
    logic np_pc = 1'b0;
    logic np_done;

    int n_tests = 0;
    int n_fail = 0;

    item_t q[$];
    logic m_valid = 1'b0;
    logic m_ovr = 1'b0;
    logic m_prev = 1'b0;
    logic checking = 1'b0;
    logic [7:0] cur_d = '0;
    logic cur_par = 1'b0;

    uart_rx_datapath_if #(.DATA_BITS(8)) rif ();
    uart_rx_datapath_if #(.DATA_BITS(8)) rif_np ();

    uart_rx_datapath #(
        .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .rxd_in(rxd_in),
        .rxd_shift(rxd_shift), .rxd_count(rxd_count),
        .clear_bit(clear_bit), .load_shift(load_shift),
        .parity_check(parity_check), .bit_done(bit_done),
        .rx_if(rif)
    );

    uart_rx_datapath #(
        .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) dut_np (
        .clk(clk), .reset(reset), .rxd_in(np_rxd),
        .rxd_shift(np_shift), .rxd_count(np_count),
        .clear_bit(np_clear), .load_shift(np_load),
        .parity_check(np_pc), .bit_done(np_done),
        .rx_if(rif_np)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: one-entry store, commit on load rising edge.
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_prev  <= 1'b0;
            q.delete();
        end else begin
            m_prev <= load_shift;
            m_ovr  <= 1'b0;
            if (load_shift && !m_prev) begin
                if (m_valid && !rif.rx_ready) begin
                    m_ovr <= 1'b1;
                end else begin
                    q.push_back('{d: cur_d,
                        pe: parity_check & ((^cur_d) ^ cur_par),
                        fe: ~rxd_in});
                    m_valid <= 1'b1;
                end
            end else if (m_valid && rif.rx_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Monitor: compare presented entry, pop when it is accepted.
    always @(negedge clk) begin
        if (!reset && checking) begin
            chk("rx_valid", rif.rx_valid, m_valid);
            chk("overrun_err", rif.overrun_err, m_ovr);
            if (rif.rx_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: got valid expected none");
                end else begin
                    chk("rx_data", rif.rx_data, q[0].d);
                    chk("parity_err", rif.parity_err, q[0].pe);
                    chk("frame_err", rif.frame_err, q[0].fe);
                    if (rif.rx_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop, input logic pc,
                              input logic rdy_c, input logic rdy_a,
                              input int nhold);
        clear_bit = 1'b1;
        idle(1);
        clear_bit = 1'b0;
        chk("clr_bit_done", bit_done, 1'b0);
        for (int i = 0; i < 9; i++) begin
            rxd_in = (i < 8) ? d[i] : par;
            rxd_shift = 1'b1;
            rxd_count = 1'b1;
            idle(1);
        end
        rxd_shift = 1'b0;
        rxd_count = 1'b0;
        chk("bit_done", bit_done, 1'b1);
        cur_d = d;
        cur_par = par;
        rxd_in = stop;
        parity_check = pc;
        rif.rx_ready = rdy_c;
        load_shift = 1'b1;
        idle(1);
        rxd_in = 1'b1;
        parity_check = 1'b0;
        rif.rx_ready = rdy_a;
        if (nhold > 1) idle(nhold - 1);
        load_shift = 1'b0;
        idle(1);
    endtask

    initial begin
        rif.rx_ready = 1'b0;
        rif_np.rx_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        chk("rst_bit_done", bit_done, 1'b0);
        chk("rst_valid", rif.rx_valid, 1'b0);
        chk("rst_perr", rif.parity_err, 1'b0);
        chk("rst_ferr", rif.frame_err, 1'b0);
        chk("rst_ovr", rif.overrun_err, 1'b0);
        checking = 1'b1;

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("a5_data", rif.rx_data, 8'hA5);
        chk("a5_perr", rif.parity_err, 1'b0);
        chk("a5_ferr", rif.frame_err, 1'b0);
        rif.rx_ready = 1'b1;
        idle(2);

        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        chk("3c_data", rif.rx_data, 8'h3C);
        chk("3c_perr", rif.parity_err, 1'b1);
        rif.rx_ready = 1'b1;
        idle(2);

        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("ovr_keep", rif.rx_data, 8'h11);
        rif.rx_ready = 1'b1;
        idle(1);
        chk("ovr_drain", rif.rx_valid, 1'b0);
        idle(1);

        send_frame(8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        chk("hold_keep", rif.rx_data, 8'h66);
        rif.rx_ready = 1'b1;
        idle(2);

        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        send_frame(8'h9E, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        chk("swap_data", rif.rx_data, 8'h9E);
        chk("swap_ferr", rif.frame_err, 1'b1);
        rif.rx_ready = 1'b1;
        idle(2);

        clear_bit = 1'b1;
        idle(1);
        clear_bit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rxd_in = i[0];
            rxd_shift = 1'b1;
            rxd_count = 1'b1;
            idle(1);
        end
        reset = 1'b1;
        load_shift = 1'b1;
        idle(1);
        reset = 1'b0;
        load_shift = 1'b0;
        rxd_shift = 1'b0;
        rxd_count = 1'b0;
        chk("mid_rst_done", bit_done, 1'b0);
        chk("mid_rst_valid", rif.rx_valid, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        chk("5a_data", rif.rx_data, 8'h5A);
        rif.rx_ready = 1'b1;
        idle(2);

        for (int k = 0; k < 30; k++) begin
            logic [7:0] rd;
            rd = 8'($urandom);
            send_frame(rd, 1'($urandom), ($urandom_range(0, 3) != 0),
                       1'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(1, 3));
        end
        rif.rx_ready = 1'b1;
        idle(3);
        chk("sb_drained", q.size(), 0);

        np_clear = 1'b1;
        idle(1);
        np_clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            np_rxd = i[2] | (i == 2) ? 1'b1 : 1'b0;
            np_rxd = (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0;
            np_shift = 1'b1;
            np_count = 1'b1;
            idle(1);
        end
        np_shift = 1'b0;
        np_count = 1'b0;
        chk("np_bit_done", np_done, 1'b1);
        np_rxd = 1'b1;
        np_pc = 1'b1;
        np_load = 1'b1;
        idle(1);
        np_load = 1'b0;
        np_pc = 1'b0;
        chk("np_valid", rif_np.rx_valid, 1'b1);
        chk("np_data", rif_np.rx_data, 8'h3C);
        chk("np_perr", rif_np.parity_err, 1'b0);
        chk("np_ferr", rif_np.frame_err, 1'b0);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
